// File: rtl/minibyte_bus_pkg.sv
// -----------------------------------------------------------------------------
// minibyte_bus_pkg
// Shared definitions for the internal 8-bit bus of the minibyte CPU.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, TURN)
//   BUS_W       : internal bus width
//   SRC_*       : request/grant bit positions of the standard bus sources
// -----------------------------------------------------------------------------
package minibyte_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int BUS_W = 8;

    localparam int SRC_ACC = 0;
    localparam int SRC_PC  = 1;
    localparam int SRC_MAR = 2;
    localparam int SRC_MEM = 3;

endpackage

// File: rtl/bus_drive_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The search starts one position after
// rr_ptr and wraps, so the most recent owner is always the last candidate.
// Ports:
//   req    in   N_REQ   request vector
//   rr_ptr in   IDX_W   index of the most recent owner
//   gnt    out  N_REQ   one-hot selected request (0 when none)
//   idx    out  IDX_W   index of the selected request
//   any    out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import minibyte_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the candidates in rotation order and keep the first one found.
    always_comb begin : p_pick
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(rr_ptr) + i) % N_REQ;
            if (!any && req[IDX_W'(k)]) begin
                any              = 1'b1;
                idx              = IDX_W'(k);
                gnt[IDX_W'(k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// -----------------------------------------------------------------------------
// bus_drive_arbiter
// Round-robin owner selection for the shared internal bus. Produces a
// registered one-hot grant that feeds each source's drive enable, and inserts
// TURNAROUND dead cycles between owners so no two drivers ever overlap.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (tenure limit with forced release).
// Ports:
//   clk            in   1        system clock, rising edge
//   rst            in   1        asynchronous active-high reset
//   req            in   N_REQ    level requests, held while the bus is needed
//   grant          out  N_REQ    registered one-hot grant
//   bus_busy       out  1        high while any grant bit is set
//   owner_id       out  IDX_W    current owner, or last owner while idle
//   tenure_expired out  1        one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module bus_drive_arbiter
    import minibyte_bus_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int TURNAROUND = 1,
    parameter  int MAX_TENURE = 15,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             bus_busy,
    output logic [IDX_W-1:0] owner_id,
    output logic             tenure_expired
);

    // Dead-cycle counter load: the release edge itself is the first dead
    // cycle's start, so TURN waits TURNAROUND-1 further edges before picking.
    localparam logic [1:0] TURN_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

    if (N_REQ < 2 || N_REQ > 8 || TURNAROUND < 0 || TURNAROUND > 3 ||
        MAX_TENURE < 1 || MAX_TENURE > 255) begin : g_badConfig
        $error("bus_drive_arbiter: parameter out of range");
    end

    arb_state_t       r_state, w_stateNext;
    logic [N_REQ-1:0] r_grant, w_grantNext;
    logic [IDX_W-1:0] r_owner, w_ownerNext;
    logic [IDX_W-1:0] r_rrPtr, w_rrPtrNext;
    logic [1:0]       r_turnCnt, w_turnCntNext;
    logic             r_busy;
    logic             w_doPick;
    logic             w_newGrant;
    logic             w_ownerReq;
    logic             w_forceRelease;

    logic [N_REQ-1:0] w_pickGnt;
    logic [IDX_W-1:0] w_pickIdx;
    logic             w_pickAny;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rrPick (
        .req    (req),
        .rr_ptr (r_rrPtr),
        .gnt    (w_pickGnt),
        .idx    (w_pickIdx),
        .any    (w_pickAny)
    );

    assign w_ownerReq = req[r_owner];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE);

    logic [7:0] r_tenure;
    logic [7:0] w_tenureInc;
    logic       r_expired;

    // The counter holds the number of completed grant cycles and saturates
    // at the limit, so a lone owner keeps the bus and a late competitor
    // triggers release on the very next edge.
    assign w_tenureInc    = (r_tenure < TENURE_MAX) ? r_tenure + 8'd1 : r_tenure;
    assign w_forceRelease = (r_state == GRANT) && w_ownerReq &&
                            (w_tenureInc == TENURE_MAX) && (|(req & ~r_grant));

    // Tenure counter restarts on every new grant, including back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tenure  <= 8'd0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= w_forceRelease;
            if (w_newGrant) begin
                r_tenure <= 8'd0;
            end else if (r_state == GRANT) begin
                r_tenure <= w_tenureInc;
            end
        end
    end

    assign tenure_expired = r_expired;
`else
    assign w_forceRelease = 1'b0;
    assign tenure_expired = 1'b0;
`endif

    // Next-state logic. A pick is requested from IDLE, from the end of TURN,
    // or directly on the release edge when no dead cycles are configured;
    // the pick itself is resolved once after the case so all three paths
    // share the same grant/pointer update.
    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grant;
        w_ownerNext   = r_owner;
        w_rrPtrNext   = r_rrPtr;
        w_turnCntNext = r_turnCnt;
        w_doPick      = 1'b0;
        w_newGrant    = 1'b0;

        case (r_state)
            IDLE: begin
                w_doPick = 1'b1;
            end
            GRANT: begin
                if (!w_ownerReq || w_forceRelease) begin
                    w_grantNext = '0;
                    if (TURNAROUND == 0) begin
                        w_doPick = 1'b1;
                    end else begin
                        w_stateNext   = TURN;
                        w_turnCntNext = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                w_grantNext = '0;
                if (r_turnCnt != 2'd0) begin
                    w_turnCntNext = r_turnCnt - 2'd1;
                end else begin
                    w_doPick = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_grantNext = '0;
            end
        endcase

        if (w_doPick) begin
            if (w_pickAny) begin
                w_stateNext = GRANT;
                w_grantNext = w_pickGnt;
                w_ownerNext = w_pickIdx;
                w_rrPtrNext = w_pickIdx;
                w_newGrant  = 1'b1;
            end else begin
                w_stateNext = IDLE;
                w_grantNext = '0;
            end
        end
    end

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_rrPtr   <= IDX_W'(N_REQ - 1);
            r_turnCnt <= 2'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_grant   <= w_grantNext;
            r_owner   <= w_ownerNext;
            r_rrPtr   <= w_rrPtrNext;
            r_turnCnt <= w_turnCntNext;
            r_busy    <= |w_grantNext;
        end
    end

    assign grant    = r_grant;
    assign bus_busy = r_busy;
    assign owner_id = r_owner;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_drive_arbiter
// Drives two arbiters from the same request vector: one with a single dead
// cycle between owners and one with none. Both are compared every cycle with
// a small owner/wait/tenure model, and the directed scenarios also compare
// against hand-written grant sequences.
// Honours BUS_ARB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bus_drive_arbiter;

    localparam int N    = 4;
    localparam int MAXT = 4;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] grantA, grantB;
    logic       busyA, busyB;
    logic [1:0] idA, idB;
    logic       expA, expB;

    int nChecks = 0;
    int nErrors = 0;

    // Model state per DUT (index 0: one dead cycle, index 1: none).
    int         mOwner[2];
    int         mLast[2];
    int         mWait[2];
    int         mHeld[2];
    int         expId[2];
    logic [3:0] expGrant[2];
    logic       expExp[2];

    always #5 clk = ~clk;

    bus_drive_arbiter #(.N_REQ(N), .TURNAROUND(1), .MAX_TENURE(MAXT)) dutTa1 (
        .clk(clk), .rst(rst), .req(req), .grant(grantA), .bus_busy(busyA),
        .owner_id(idA), .tenure_expired(expA)
    );

    bus_drive_arbiter #(.N_REQ(N), .TURNAROUND(0), .MAX_TENURE(MAXT)) dutTa0 (
        .clk(clk), .rst(rst), .req(req), .grant(grantB), .bus_busy(busyB),
        .owner_id(idB), .tenure_expired(expB)
    );

    function automatic int taOf(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Next requester after 'last' in circular order, or -1 if none.
    function automatic int pickIdx(input logic [3:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[2'((last + i) % N)]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mOwner[d]   = -1;
            mLast[d]    = N - 1;
            mWait[d]    = 1;
            mHeld[d]    = 0;
            expId[d]    = 0;
            expGrant[d] = 4'b0000;
            expExp[d]   = 1'b0;
        end
    endtask

    // One clock edge of the bus ownership rules, for both configurations.
    // mWait is the number of edges still to come before a pick may happen.
    task automatic modelEdge(input logic [3:0] r);
        for (int d = 0; d < 2; d++) begin
            bit keep;
            bit pickNow;
            int k;
            keep      = 1'b0;
            pickNow   = 1'b0;
            expExp[d] = 1'b0;
            if (mOwner[d] >= 0) begin
                keep = r[2'(mOwner[d])];
                if (mHeld[d] < 255) mHeld[d]++;
                if (TIMEOUT_ON && keep && ((r & ~(4'b0001 << mOwner[d])) != 4'b0000)
                    && mHeld[d] >= MAXT) begin
                    keep      = 1'b0;
                    expExp[d] = 1'b1;
                end
                if (!keep) begin
                    mOwner[d] = -1;
                    mWait[d]  = taOf(d);
                    pickNow   = (taOf(d) == 0);
                end
            end else if (mWait[d] > 1) begin
                mWait[d]--;
            end else begin
                pickNow = 1'b1;
            end
            if (pickNow) begin
                k = pickIdx(r, mLast[d]);
                if (k >= 0) begin
                    mOwner[d] = k;
                    mLast[d]  = k;
                    expId[d]  = k;
                    mHeld[d]  = 0;
                end
                mWait[d] = 1;
            end
            expGrant[d] = (mOwner[d] >= 0) ? (4'b0001 << mOwner[d]) : 4'b0000;
        end
    endtask

    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        modelEdge(r);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL reset_grantA got %b want 0000", grantA); end
        nChecks++; if (grantB !== 4'b0000) begin nErrors++; $display("[TB] FAIL reset_grantB got %b want 0000", grantB); end
        nChecks++; if (busyA !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_busyA got %b want 0", busyA); end
        nChecks++; if (idA !== 2'd0) begin nErrors++; $display("[TB] FAIL reset_idA got %0d want 0", idA); end
        nChecks++; if (expA !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_expA got %b want 0", expA); end
        rst = 1'b0;
        tick(4'b1111);
        nChecks++; if (grantA !== 4'b0001) begin nErrors++; $display("[TB] FAIL first_grantA got %b want 0001", grantA); end
        nChecks++; if (grantB !== 4'b0001) begin nErrors++; $display("[TB] FAIL first_grantB got %b want 0001", grantB); end
        nChecks++; if (idA !== 2'd0) begin nErrors++; $display("[TB] FAIL first_idA got %0d want 0", idA); end
        nChecks++; if (busyA !== 1'b1) begin nErrors++; $display("[TB] FAIL first_busyA got %b want 1", busyA); end
        tick(4'b1111);
        #2;
        rst = 1'b1;
        #1;
        nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL midrst_grantA got %b want 0000", grantA); end
        nChecks++; if (grantB !== 4'b0000) begin nErrors++; $display("[TB] FAIL midrst_grantB got %b want 0000", grantB); end
        nChecks++; if (busyA !== 1'b0) begin nErrors++; $display("[TB] FAIL midrst_busyA got %b want 0", busyA); end
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0] dropMask;
        logic [3:0] want;
        doReset();
        tick(4'b1111);
        nChecks++; if (grantA !== 4'b0001) begin nErrors++; $display("[TB] FAIL rot_start got %b want 0001", grantA); end
        for (int g = 0; g < 4; g++) begin
            dropMask = 4'b1111 & ~(4'b0001 << g);
            tick(dropMask);
            nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL rot_dead%0d got %b want 0000", g, grantA); end
            nChecks++; if (grantB !== expGrant[1]) begin nErrors++; $display("[TB] FAIL rot_b_rel%0d got %b want %b", g, grantB, expGrant[1]); end
            tick(4'b1111);
            want = 4'b0001 << ((g + 1) % 4);
            nChecks++; if (grantA !== want) begin nErrors++; $display("[TB] FAIL rot_next%0d got %b want %b", g, grantA, want); end
            nChecks++; if (idA !== 2'((g + 1) % 4)) begin nErrors++; $display("[TB] FAIL rot_id%0d got %0d want %0d", g, idA, (g + 1) % 4); end
            nChecks++; if (grantB !== expGrant[1]) begin nErrors++; $display("[TB] FAIL rot_b_next%0d got %b want %b", g, grantB, expGrant[1]); end
        end
    endtask

    task automatic test_turnaround();
        doReset();
        tick(4'b0100);
        nChecks++; if (grantA !== 4'b0100) begin nErrors++; $display("[TB] FAIL ta_ownA got %b want 0100", grantA); end
        tick(4'b0101);
        nChecks++; if (grantB !== 4'b0100) begin nErrors++; $display("[TB] FAIL ta_holdB got %b want 0100", grantB); end
        tick(4'b0001);
        nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL ta_deadA got %b want 0000", grantA); end
        nChecks++; if (grantB !== 4'b0001) begin nErrors++; $display("[TB] FAIL ta_b2bB got %b want 0001", grantB); end
        tick(4'b0001);
        nChecks++; if (grantA !== 4'b0001) begin nErrors++; $display("[TB] FAIL ta_nextA got %b want 0001", grantA); end
        nChecks++; if (idA !== 2'd0) begin nErrors++; $display("[TB] FAIL ta_idA got %0d want 0", idA); end
    endtask

    task automatic test_drop_during_turn();
        doReset();
        tick(4'b0100);
        tick(4'b0010);
        nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL dt_relA got %b want 0000", grantA); end
        nChecks++; if (grantB !== expGrant[1]) begin nErrors++; $display("[TB] FAIL dt_relB got %b want %b", grantB, expGrant[1]); end
        tick(4'b0000);
        nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL dt_pickA got %b want 0000", grantA); end
        tick(4'b0000);
        nChecks++; if (grantA !== 4'b0000) begin nErrors++; $display("[TB] FAIL dt_idleA got %b want 0000", grantA); end
        nChecks++; if (idA !== 2'd2) begin nErrors++; $display("[TB] FAIL dt_idA got %0d want 2", idA); end
        tick(4'b1000);
        nChecks++; if (grantA !== 4'b1000) begin nErrors++; $display("[TB] FAIL dt_newA got %b want 1000", grantA); end
        nChecks++; if (grantB !== expGrant[1]) begin nErrors++; $display("[TB] FAIL dt_newB got %b want %b", grantB, expGrant[1]); end
    endtask

    task automatic test_timeout();
        logic [3:0] wantA;
        logic       wantExp;
        doReset();
        tick(4'b1000);
        for (int i = 0; i < 4; i++) begin
            tick(4'b1010);
            wantA   = (TIMEOUT_ON && i == 3) ? 4'b0000 : 4'b1000;
            wantExp = TIMEOUT_ON && i == 3;
            nChecks++; if (grantA !== wantA) begin nErrors++; $display("[TB] FAIL to_grantA%0d got %b want %b", i, grantA, wantA); end
            nChecks++; if (expA !== wantExp) begin nErrors++; $display("[TB] FAIL to_expA%0d got %b want %b", i, expA, wantExp); end
            nChecks++; if (grantB !== expGrant[1]) begin nErrors++; $display("[TB] FAIL to_grantB%0d got %b want %b", i, grantB, expGrant[1]); end
            nChecks++; if (expB !== expExp[1]) begin nErrors++; $display("[TB] FAIL to_expB%0d got %b want %b", i, expB, expExp[1]); end
        end
        tick(4'b1010);
        wantA = TIMEOUT_ON ? 4'b0010 : 4'b1000;
        nChecks++; if (grantA !== wantA) begin nErrors++; $display("[TB] FAIL to_afterA got %b want %b", grantA, wantA); end
        nChecks++; if (expA !== 1'b0) begin nErrors++; $display("[TB] FAIL to_pulseA got %b want 0", expA); end
        doReset();
        tick(4'b1000);
        for (int i = 0; i < 8; i++) begin
            tick(4'b1000);
            nChecks++; if (grantA !== 4'b1000) begin nErrors++; $display("[TB] FAIL solo_grantA%0d got %b want 1000", i, grantA); end
            nChecks++; if (expA !== 1'b0) begin nErrors++; $display("[TB] FAIL solo_expA%0d got %b want 0", i, expA); end
        end
    endtask

    task automatic test_random();
        logic [3:0] cur;
        logic [3:0] prevA;
        doReset();
        cur   = 4'b0000;
        prevA = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if (cur[b]) begin
                    if ($urandom_range(0, 3) == 0) cur[b] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    cur[b] = 1'b1;
                end
            end
            tick(cur);
            nChecks++; if (grantA !== expGrant[0]) begin nErrors++; $display("[TB] FAIL rnd_grantA c%0d got %b want %b", c, grantA, expGrant[0]); end
            nChecks++; if (grantB !== expGrant[1]) begin nErrors++; $display("[TB] FAIL rnd_grantB c%0d got %b want %b", c, grantB, expGrant[1]); end
            nChecks++; if (idA !== 2'(expId[0])) begin nErrors++; $display("[TB] FAIL rnd_idA c%0d got %0d want %0d", c, idA, expId[0]); end
            nChecks++; if (idB !== 2'(expId[1])) begin nErrors++; $display("[TB] FAIL rnd_idB c%0d got %0d want %0d", c, idB, expId[1]); end
            nChecks++; if (busyA !== (|expGrant[0])) begin nErrors++; $display("[TB] FAIL rnd_busyA c%0d got %b want %b", c, busyA, |expGrant[0]); end
            nChecks++; if (busyB !== (|expGrant[1])) begin nErrors++; $display("[TB] FAIL rnd_busyB c%0d got %b want %b", c, busyB, |expGrant[1]); end
            nChecks++; if (expA !== expExp[0]) begin nErrors++; $display("[TB] FAIL rnd_expA c%0d got %b want %b", c, expA, expExp[0]); end
            nChecks++; if (expB !== expExp[1]) begin nErrors++; $display("[TB] FAIL rnd_expB c%0d got %b want %b", c, expB, expExp[1]); end
            nChecks++; if (!$onehot0(grantB)) begin nErrors++; $display("[TB] FAIL rnd_onehotB c%0d got %b want onehot0", c, grantB); end
            nChecks++; if (prevA != 4'b0000 && grantA != prevA && grantA != 4'b0000) begin nErrors++; $display("[TB] FAIL rnd_deadA c%0d got %b after %b want 0000", c, grantA, prevA); end
            prevA = grantA;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        modelReset();
        test_reset();
        test_rotation();
        test_turnaround();
        test_drop_during_turn();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
